// File: rtl/router_pkt_fifo.sv
// Packet-aware channel FIFO: stores {header_tag, data}, flags SOP/EOP on the read side,
// and reports fill level, almost-full/empty thresholds and sticky overflow/underflow.
module router_pkt_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int LEN_MSB   = 7,
    parameter int LEN_LSB   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     lfd_state,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     read_enb,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     sop,
    output logic                     eop,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = LEN_MSB - LEN_LSB + 2;
    localparam logic [AW:0]   AFULL_L  = AFULL_TH[AW:0];
    localparam logic [AW:0]   AEMPTY_L = AEMPTY_TH[AW:0];
    localparam logic [AW:0]   PTR_ONE  = 1;
    localparam logic [CW-1:0] REM_ONE  = 1;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [CW-1:0]    r_rem_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_sop;
    logic             r_eop;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH:0]   w_rd_word;
    logic [CW-2:0]    w_len;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr      = write_enb && !w_full && !soft_reset;
    assign w_rd      = read_enb && !w_empty && !soft_reset;
    assign w_rd_word = r_mem[r_rptr[AW-1:0]];
    assign w_len     = w_rd_word[LEN_MSB:LEN_LSB];

    assign fill_level   = r_wptr - r_rptr;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (fill_level >= AFULL_L);
    assign almost_empty = (fill_level <= AEMPTY_L);
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign sop          = r_sop;
    assign eop          = r_eop;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage is never cleared; flushes only move the pointers.
    always_ff @(posedge clock) begin
        if (w_wr && !reset) begin
            r_mem[r_wptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    // Read side: data_valid is a one-cycle strobe meaning data_out holds the word popped by the
    // read accepted on the previous edge; there is no backpressure, the consumer must take it then.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_rem_cnt    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (soft_reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_rem_cnt    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (write_enb && w_full) begin
                r_overflow <= 1'b1;
            end
            if (read_enb && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_rd) begin
                r_rptr       <= r_rptr + PTR_ONE;
                r_data_out   <= w_rd_word[WIDTH-1:0];
                r_data_valid <= 1'b1;
                if (w_rd_word[WIDTH]) begin
                    // A header always restarts the tracker, even mid-packet.
                    r_sop     <= 1'b1;
                    r_eop     <= 1'b0;
                    r_rem_cnt <= {1'b0, w_len} + REM_ONE;
                end else if (r_rem_cnt != '0) begin
                    r_sop     <= 1'b0;
                    r_eop     <= (r_rem_cnt == REM_ONE);
                    r_rem_cnt <= r_rem_cnt - REM_ONE;
                end else begin
                    r_sop <= 1'b0;
                    r_eop <= 1'b0;
                end
            end else begin
                r_data_valid <= 1'b0;
                r_sop        <= 1'b0;
                r_eop        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: fixed vector table, hand-written corner sequences and random
// traffic checked against a queue-based reference model.
module tb_router_pkt_fifo;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sop;
    logic       eop;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] fill_level;
    logic       overflow;
    logic       underflow;

    router_pkt_fifo dut (
        .clock        (clock),
        .reset        (reset),
        .soft_reset   (soft_reset),
        .write_enb    (write_enb),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .read_enb     (read_enb),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .sop          (sop),
        .eop          (eop),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: stored words as a queue of {tag, data}
    logic [8:0] exp_q[$];
    logic [7:0] m_dout;
    logic       m_valid, m_sop, m_eop, m_ovf, m_udf;
    int         m_rem;

    typedef struct {
        logic       we;
        logic       lfd;
        logic [7:0] din;
        logic       re;
        logic       ev;
        logic       es;
        logic       ee;
        logic [7:0] ed;
        logic [4:0] ef;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_rem   = 0;
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic lfd, input logic [7:0] din,
                              input logic re, input logic srst);
        logic       was_full;
        logic       was_empty;
        logic [8:0] w;
        if (srst) begin
            model_clear();
            return;
        end
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (we && was_full) m_ovf = 1'b1;
        if (re && was_empty) m_udf = 1'b1;
        if (re && !was_empty) begin
            w       = exp_q.pop_front();
            m_valid = 1'b1;
            m_dout  = w[7:0];
            if (w[8]) begin
                m_sop = 1'b1;
                m_eop = 1'b0;
                m_rem = int'(w[7:2]) + 1;
            end else if (m_rem != 0) begin
                m_sop = 1'b0;
                m_eop = (m_rem == 1);
                m_rem = m_rem - 1;
            end else begin
                m_sop = 1'b0;
                m_eop = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            m_sop   = 1'b0;
            m_eop   = 1'b0;
        end
        if (we && !was_full) exp_q.push_back({lfd, din});
    endtask

    task automatic check_model(input string t);
        int n;
        n = exp_q.size();
        chk({t, ".dout"},  32'(data_out),     32'(m_dout));
        chk({t, ".valid"}, 32'(data_valid),   32'(m_valid));
        chk({t, ".sop"},   32'(sop),          32'(m_sop));
        chk({t, ".eop"},   32'(eop),          32'(m_eop));
        chk({t, ".fill"},  32'(fill_level),   32'(n));
        chk({t, ".empty"}, 32'(empty),        32'(n == 0));
        chk({t, ".full"},  32'(full),         32'(n == DEPTH));
        chk({t, ".aempty"},32'(almost_empty), 32'(n <= 2));
        chk({t, ".afull"}, 32'(almost_full),  32'(n >= DEPTH - 2));
        chk({t, ".ovf"},   32'(overflow),     32'(m_ovf));
        chk({t, ".udf"},   32'(underflow),    32'(m_udf));
    endtask

    // Entered and left at a falling edge; the model steps at the rising edge.
    task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                        input logic re, input logic srst);
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = srst;
        @(posedge clock);
        model_step(we, lfd, din, re, srst);
        @(negedge clock);
    endtask

    task automatic do_reset();
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
        tbl[1]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2};
        tbl[2]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd3};
        tbl[3]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd4};
        tbl[4]  = '{1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd5};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0C, 5'd4};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 5'd3};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 5'd2};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 5'd1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 5'd0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 5'd0};
        tbl[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 5'd1};
        tbl[12] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 5'd2};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 5'd0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd0};

        @(negedge clock);
        do_reset();
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.aempty", 32'(almost_empty), 32'd1);
        chk("rst.fill", 32'(fill_level), 32'd0);
        check_model("rst");

        // single packet and zero-length packet
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].we, tbl[i].lfd, tbl[i].din, tbl[i].re, 1'b0);
            chk($sformatf("vec%0d.valid", i), 32'(data_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d.sop", i),   32'(sop),        32'(tbl[i].es));
            chk($sformatf("vec%0d.eop", i),   32'(eop),        32'(tbl[i].ee));
            chk($sformatf("vec%0d.dout", i),  32'(data_out),   32'(tbl[i].ed));
            chk($sformatf("vec%0d.fill", i),  32'(fill_level), 32'(tbl[i].ef));
        end
        chk("pkt.empty", 32'(empty), 32'd1);

        // fill to full, then one dropped write
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            chk($sformatf("fill%0d.afull", i + 1), 32'(almost_full), 32'(i + 1 >= 14));
            chk($sformatf("fill%0d.full", i + 1), 32'(full), 32'(i + 1 == DEPTH));
        end
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        chk("fill17.fill", 32'(fill_level), 32'd16);
        chk("fill17.ovf", 32'(overflow), 32'd1);
        check_model("fill17");

        // read+write at full, drain, read+write at empty
        step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        chk("edge_full.fill", 32'(fill_level), 32'd15);
        chk("edge_full.valid", 32'(data_valid), 32'd1);
        check_model("edge_full");
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check_model($sformatf("drain%0d", i));
        end
        step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        chk("edge_empty.fill", 32'(fill_level), 32'd1);
        chk("edge_empty.valid", 32'(data_valid), 32'd0);
        chk("edge_empty.udf", 32'(underflow), 32'd1);

        // soft reset, preload 3, then 40 cycles of read+write across the wrap
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("srst.empty", 32'(empty), 32'd1);
        chk("srst.udf", 32'(underflow), 32'd0);
        chk("srst.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            chk($sformatf("wrap%0d.fill", i), 32'(fill_level), 32'd3);
            check_model($sformatf("wrap%0d", i));
        end

        // flush mid-packet: tracker must forget the open packet
        step(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush.empty", 32'(empty), 32'd1);
        chk("flush.dout", 32'(data_out), 32'd0);
        check_model("flush");
        step(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("stray.eop", 32'(eop), 32'd0);
        check_model("stray");

        // async reset in the middle of a read
        step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        chk("midrd.valid", 32'(data_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst.valid", 32'(data_valid), 32'd0);
        chk("arst.sop", 32'(sop), 32'd0);
        chk("arst.dout", 32'(data_out), 32'd0);
        chk("arst.fill", 32'(fill_level), 32'd0);
        chk("arst.empty", 32'(empty), 32'd1);
        chk("arst.aempty", 32'(almost_empty), 32'd1);
        chk("arst.afull", 32'(almost_full), 32'd0);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_clear();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic we_r;
            logic re_r;
            we_r = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            re_r = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(we_r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), re_r,
                 ($urandom_range(0, 99) == 0));
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
